// File: rtl/axi_master_engine.sv
// AXI3 master engine: turns one read/write burst command into AW/W/B or AR/R traffic, one transaction at a time.
// Optional response timeout is compiled in when AXI_MST_TIMEOUT_EN is defined.
module axi_master_engine #(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] MST_ID  = 4'h0,
    parameter int         TMO_CYC = 256
) (
    input  logic                  aclk,
    input  logic                  arst,
    // command / streaming side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  err,
    output logic [2:0]            dbg_state,
    // AXI write address
    output logic [3:0]            awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    // AXI write data
    output logic [3:0]            wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI write response
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI read address
    output logic [3:0]            arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    // AXI read data
    input  logic [3:0]            rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    // Every channel transfers on the cycle where valid and ready are both sampled high
    // at posedge aclk; valid never waits on ready, and payload is held until that cycle.

    localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RADDR = 3'd4,
        RDATA = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          racc_q, racc_d;
    logic [1:0]          resp_q, resp_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                rdy_q, rdy_d;

    logic in_aw, in_w, in_b, in_ar, in_r;
    logic [1:0] rresp_max;

    assign in_aw = (state_q == WADDR);
    assign in_w  = (state_q == WDATA);
    assign in_b  = (state_q == WRESP);
    assign in_ar = (state_q == RADDR);
    assign in_r  = (state_q == RDATA);

    // SLVERR/DECERR encode higher than OKAY/EXOKAY, so the worst response is the numeric max
    assign rresp_max = (rresp > racc_q) ? rresp : racc_q;

`ifdef AXI_MST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             any_hs;
    assign any_hs = (awvalid & awready) | (wvalid & wready) | (bvalid & bready)
                  | (arvalid & arready) | (rvalid & rready);
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        racc_d  = racc_q;
        resp_d  = resp_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef AXI_MST_TIMEOUT_EN
        tmo_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    racc_d  = 2'b00;
                    state_d = cmd_write ? WADDR : RADDR;
                end
            end
            WADDR: if (awready) state_d = WDATA;
            WDATA: begin
                if (wr_valid && wready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_q) state_d = WRESP;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    done_d  = 1'b1;
                    resp_d  = bresp;
                    state_d = IDLE;
                    if (bid != MST_ID) err_d = 1'b1;
                end
            end
            RADDR: if (arready) state_d = RDATA;
            RDATA: begin
                if (rvalid && rd_ready) begin
                    cnt_d  = cnt_q + 4'd1;
                    racc_d = rresp_max;
                    // rlast must coincide exactly with the beat numbered len
                    if ((rid != MST_ID) || (rlast != (cnt_q == len_q))) err_d = 1'b1;
                    if (rlast) begin
                        done_d  = 1'b1;
                        resp_d  = rresp_max;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_MST_TIMEOUT_EN
        if (state_q != IDLE && !any_hs) begin
            if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                resp_d  = 2'b10;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
        // cmd_ready stays low through the done cycle so the two never overlap
        rdy_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            racc_q  <= '0;
            resp_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef AXI_MST_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            racc_q  <= racc_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
`ifdef AXI_MST_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign cmd_ready = rdy_q;
    assign done      = done_q;
    assign done_resp = resp_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    // Address channels are zeroed outside their phase so idle outputs read as 0
    assign awvalid = in_aw;
    assign awid    = in_aw ? MST_ID : 4'h0;
    assign awaddr  = in_aw ? addr_q : '0;
    assign awlen   = in_aw ? len_q : 4'h0;
    assign awsize  = in_aw ? AX_SIZE : 3'b000;
    assign awburst = in_aw ? 2'b01 : 2'b00;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'b000;

    assign wvalid   = in_w & wr_valid;
    assign wr_ready = in_w & wready;
    assign wdata    = in_w ? wr_data : '0;
    assign wstrb    = in_w ? '1 : '0;
    assign wid      = in_w ? MST_ID : 4'h0;
    assign wlast    = in_w && (cnt_q == len_q);

    assign bready = in_b;

    assign arvalid = in_ar;
    assign arid    = in_ar ? MST_ID : 4'h0;
    assign araddr  = in_ar ? addr_q : '0;
    assign arlen   = in_ar ? len_q : 4'h0;
    assign arsize  = in_ar ? AX_SIZE : 3'b000;
    assign arburst = in_ar ? 2'b01 : 2'b00;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'b000;

    assign rready   = in_r & rd_ready;
    assign rd_valid = in_r & rvalid;
    assign rd_data  = in_r ? rdata : '0;
    assign rd_last  = in_r & rlast;

endmodule

// File: tb/tb_axi_master_engine.sv
// Bench for axi_master_engine: the bench plays command source, data source/sink and AXI responder.
// Expected beats, responses and the sticky error flag come from a transaction-level model.
module tb_axi_master_engine;

  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic          done, err;
  logic [1:0]    done_resp;
  logic [2:0]    dbg_state;
  logic [3:0]    awid, awlen, awcache, wid, bid, arid, arlen, arcache, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awsize, awprot, arsize, arprot;
  logic [1:0]    awburst, awlock, arburst, arlock, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_master_engine #(.ADDR_W(AW), .DATA_W(DW), .MST_ID(4'h0), .TMO_CYC(256)) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .err(err), .dbg_state(dbg_state),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int total = 0;
  int bad   = 0;
  logic model_err;
  logic [DW-1:0] beat_data [16];
  logic [1:0]    beat_resp [16];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      beat_data[i] = $urandom;
      case ($urandom_range(0, 3))
        0: beat_resp[i] = 2'b10;
        1: beat_resp[i] = 2'b11;
        default: beat_resp[i] = 2'b00;
      endcase
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One complete transaction, bench acting as both command source and AXI responder.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [3:0] len,
                         input int ax_delay, input logic [1:0] b_resp, input int early_last,
                         input bit bad_id, input int abort_beat);
    int n_r, r_beats, w_beats, ax_cnt, aw_cnt, cyc;
    bit accepted, ax_done, w_done, b_done, wv, bv, rv, fin, err_event;
    logic [1:0] exp_resp;
    n_r = 0; r_beats = 0; w_beats = 0; ax_cnt = 0; aw_cnt = 0; cyc = 0;
    accepted = 0; ax_done = 0; w_done = 0; b_done = 0; wv = 0; bv = 0; rv = 0; fin = 0;
    exp_q.delete();
    if (wr) for (int i = 0; i <= int'(len); i++) exp_q.push_back(beat_data[i]);
    n_r = (early_last >= 0) ? early_last + 1 : int'(len) + 1;
    exp_resp = wr ? b_resp : 2'b00;
    if (!wr) for (int i = 0; i < n_r; i++) if (beat_resp[i] > exp_resp) exp_resp = beat_resp[i];
    err_event = bad_id || (!wr && early_last >= 0 && early_last != int'(len));

    while (!fin && cyc < 300) begin
      @(posedge aclk); #1;
      cyc++;
      cmd_valid = !accepted; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      awready = wr && (ax_cnt >= ax_delay);
      arready = !wr && (ax_cnt >= ax_delay);
      if (wr && accepted && w_beats <= int'(len)) begin
        if (!wv) wv = ($urandom_range(0, 2) != 0);
      end else wv = 0;
      wr_valid = wv;
      wr_data  = (w_beats < 16) ? beat_data[w_beats] : '0;
      wready   = 1'($urandom_range(0, 1));
      if (w_done && !b_done && !bv) bv = 1'($urandom_range(0, 1));
      bvalid = bv; bresp = b_resp; bid = bad_id ? 4'h3 : 4'h0;
      if (!wr && ax_done && r_beats < n_r) begin
        if (!rv) rv = ($urandom_range(0, 2) != 0);
      end else rv = 0;
      rvalid = rv;
      rdata  = (r_beats < 16) ? beat_data[r_beats] : '0;
      rresp  = (r_beats < 16) ? beat_resp[r_beats] : 2'b00;
      rlast  = (r_beats == n_r - 1);
      rid    = bad_id ? 4'h5 : 4'h0;
      rd_ready = ($urandom_range(0, 3) != 0);
      #2;

      check("done_mid_txn", done, 0);
      if (accepted && !ax_done) begin
        if (wr) begin
          check("awvalid_held", awvalid, 1);
          check("awaddr_stable", awaddr, addr);
          check("awlen_stable", awlen, len);
          check("wvalid_pre_aw", wvalid, 0);
        end else begin
          check("arvalid_held", arvalid, 1);
          check("araddr_stable", araddr, addr);
          check("arlen_stable", arlen, len);
        end
      end
      if (wr && ax_done && !w_done) begin
        check("wvalid_pass", wvalid, wr_valid);
        check("wr_ready_pass", wr_ready, wready);
        check("wlast", wlast, (w_beats == int'(len)));
        check("wstrb", wstrb, 4'hf);
      end
      if (wr && w_done && !b_done) check("bready", bready, 1);
      if (!wr && ax_done) begin
        check("rready_pass", rready, rd_ready);
        check("rd_valid_pass", rd_valid, rvalid);
        if (rvalid) begin
          check("rd_data", rd_data, beat_data[r_beats]);
          check("rd_last", rd_last, rlast);
        end
      end

      if (cmd_valid && cmd_ready) accepted = 1;
      if (awvalid && awready) begin
        aw_cnt++; ax_done = 1;
        check("awburst", awburst, 2'b01);
        check("awsize", awsize, 3'd2);
        check("awid", awid, 4'h0);
        check("awlock_cache_prot", {awlock, awcache, awprot}, 0);
      end else if (awvalid) ax_cnt++;
      if (arvalid && arready) begin
        ax_done = 1;
        check("arburst", arburst, 2'b01);
        check("arsize", arsize, 3'd2);
        check("arid", arid, 4'h0);
      end else if (arvalid) ax_cnt++;
      if (wvalid && wready) begin
        check("w_beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("wdata", wdata, exp_q.pop_front());
        w_beats++; wv = 0;
        if (w_beats > int'(len)) w_done = 1;
      end
      if (bvalid && bready) begin b_done = 1; bv = 0; fin = 1; end
      if (rvalid && rready) begin
        r_beats++; rv = 0;
        if (rlast) fin = 1;
      end

      if (wr && abort_beat >= 0 && w_beats == abort_beat && ax_done && !fin) begin
        idle_inputs();
        arst = 1;
        @(posedge aclk); #1;
        arst = 0;
        model_err = 0;
        #2;
        check_all_quiet("abort");
        check("abort_err", err, 0);
        @(posedge aclk); #3;
        check("abort_cmd_ready", cmd_ready, 1);
        return;
      end
    end

    check("txn_complete", fin, 1);
    @(posedge aclk); #1;
    idle_inputs();
    #2;
    if (err_event) model_err = 1;
    check("done_pulse", done, 1);
    check("done_resp", done_resp, exp_resp);
    check("cmd_ready_during_done", cmd_ready, 0);
    check("err_flag", err, model_err);
    check("aw_count", aw_cnt, wr ? 1 : 0);
    @(posedge aclk); #3;
    check("done_cleared", done, 0);
    check("cmd_ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    idle_inputs();
    model_err = 0;
    arst = 1;
    repeat (2) @(posedge aclk);
    #3;
    check_all_quiet("reset");
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_err", err, 0);
    check("reset_done_resp", done_resp, 2'b00);
    check("reset_awaddr", awaddr, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_dbg_state", dbg_state, 0);
    @(posedge aclk); #1;
    arst = 0;
    @(posedge aclk); #3;
    check("cmd_ready_after_reset", cmd_ready, 1);

    // write 0x100, 4 beats of 1..4, OKAY
    fill_random();
    for (int i = 0; i < 4; i++) beat_data[i] = i + 1;
    run_txn(1, 32'h100, 4'd3, 0, 2'b00, -1, 0, -1);

    // single-beat read returning 0xCAFE
    fill_random();
    beat_data[0] = 32'hCAFE; beat_resp[0] = 2'b00;
    run_txn(0, 32'h40, 4'd0, 0, 2'b00, -1, 0, -1);

    // 3-beat read with SLVERR on beat 1
    fill_random();
    for (int i = 0; i < 16; i++) beat_resp[i] = 2'b00;
    beat_resp[1] = 2'b10;
    run_txn(0, 32'h200, 4'd2, 1, 2'b00, -1, 0, -1);

    // awready held low for 10 cycles
    fill_random();
    run_txn(1, 32'h2000, 4'd1, 10, 2'b00, -1, 0, -1);

    // single-beat write: wlast on the first beat
    fill_random();
    run_txn(1, 32'h3000, 4'd0, 0, 2'b00, -1, 0, -1);

    // randomized mix of reads and writes
    for (int t = 0; t < 20; t++) begin
      fill_random();
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))},
              -1, 0, -1);
    end

    // early rlast on beat 1 of a 3-beat read
    fill_random();
    run_txn(0, 32'h80, 4'd2, 0, 2'b00, 1, 0, -1);

    // reset during write beat 2, then a normal write
    fill_random();
    run_txn(1, 32'h300, 4'd5, 0, 2'b00, -1, 0, 2);
    fill_random();
    run_txn(1, 32'h400, 4'd2, 0, 2'b00, -1, 0, -1);

    // wrong bid raises the sticky error
    fill_random();
    run_txn(1, 32'h500, 4'd1, 0, 2'b00, -1, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
